// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if
// Bundles the control/status signals between the stage sequencer and the
// stages and core around it.
//   master : the sequencer. It drives the stage enables, pc and status, and
//            receives run, stage_done, skip_mask, next_pc, flush and flush_pc.
//   slave  : the surrounding core and stages. It has the opposite directions.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32
);
  localparam int STAGE_W = $clog2(NUM_STAGES);

  logic                  run;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] skip_mask;
  logic [ADDR_W-1:0]     next_pc;
  logic                  flush;
  logic [ADDR_W-1:0]     flush_pc;
  logic [ADDR_W-1:0]     pc;
  logic [STAGE_W-1:0]    cur_stage;
  logic                  busy;
  logic                  retire;
  logic [CNT_W-1:0]      instret;
  logic                  timeout_err;
  logic [STAGE_W-1:0]    err_stage;

  modport master (
    input  run, stage_done, skip_mask, next_pc, flush, flush_pc,
    output stage_en, pc, cur_stage, busy, retire, instret, timeout_err, err_stage
  );

  modport slave (
    output run, stage_done, skip_mask, next_pc, flush, flush_pc,
    input  stage_en, pc, cur_stage, busy, retire, instret, timeout_err, err_stage
  );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer
// Parametrised multi-cycle control sequencer. It steps through NUM_STAGES
// stages one at a time. Each stage gets a one-cycle enable pulse, and the
// sequencer then waits for that stage's done. Stages set in skip_mask are
// bypassed. The sequencer also handles flush/redirect, run gating at
// instruction boundaries, a wait timeout with a sticky error, and a
// retired-instruction counter. It owns the architectural pc.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : stage_sequencer_if.master
//            in : run, stage_done, skip_mask, next_pc, flush, flush_pc
//            out: stage_en, pc, cur_stage, busy, retire, instret,
//                 timeout_err, err_stage
module stage_sequencer #(
  parameter int                NUM_STAGES = 5,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                TIMEOUT    = 1024,
  parameter int                CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  stage_sequencer_if.master       bus
);

  localparam int STAGE_W = $clog2(NUM_STAGES);
  // The wait counter only has to reach TIMEOUT-1.
  localparam int WCNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [ADDR_W-1:0]  pc_q,        pc_d;
  logic [STAGE_W-1:0] cur_stage_q, cur_stage_d;
  logic               retire_q,    retire_d;
  logic [CNT_W-1:0]   instret_q,   instret_d;
  logic [STAGE_W-1:0] err_stage_q, err_stage_d;
  logic [WCNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

  logic [STAGE_W:0]   nxt;          // {found, index}
  logic               cur_done;
  logic               wait_expired;

  // Finds the lowest stage above cur that is not skipped.
  // The descending scan lets the lowest match be written last.
  function automatic logic [STAGE_W:0] find_next(
    input logic [STAGE_W-1:0]    cur,
    input logic [NUM_STAGES-1:0] mask
  );
    logic [STAGE_W:0] r;
    r = '0;
    for (int j = NUM_STAGES - 1; j >= 1; j--) begin
      if ((j > int'(cur)) && !mask[j]) begin
        r = {1'b1, STAGE_W'(j)};
      end
    end
    return r;
  endfunction

  always_comb begin
    nxt          = find_next(cur_stage_q, bus.skip_mask);
    // Only the bit of the current stage is looked at.
    cur_done     = bus.stage_done[cur_stage_q];
    wait_expired = (TIMEOUT > 0) && (wait_cnt_q == WCNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cur_stage_d = cur_stage_q;
    retire_d    = 1'b0;
    instret_d   = instret_q;
    err_stage_d = err_stage_q;
    wait_cnt_d  = wait_cnt_q;

    // Flush takes priority over done and timeout in every live state.
    // An enable pulse already out in this cycle is not withdrawn.
    if (bus.flush && (state_q != S_ERROR)) begin
      pc_d        = bus.flush_pc;
      cur_stage_d = '0;
      state_d     = bus.run ? S_ISSUE : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            cur_stage_d = '0;
            state_d     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (cur_done) begin
            if (nxt[STAGE_W]) begin
              cur_stage_d = nxt[STAGE_W-1:0];
              state_d     = S_ISSUE;
            end else begin
              // Last executed stage is done, so the instruction retires here.
              // run is sampled at this boundary, which lets the next
              // instruction start back-to-back.
              pc_d        = bus.next_pc;
              retire_d    = 1'b1;
              instret_d   = instret_q + CNT_W'(1);
              cur_stage_d = '0;
              state_d     = bus.run ? S_ISSUE : S_IDLE;
            end
          end else if (wait_expired) begin
            err_stage_d = cur_stage_q;
            state_d     = S_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end
        default: begin
          // ERROR is sticky until rst.
          state_d = S_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      cur_stage_q <= '0;
      retire_q    <= 1'b0;
      instret_q   <= '0;
      err_stage_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cur_stage_q <= cur_stage_d;
      retire_q    <= retire_d;
      instret_q   <= instret_d;
      err_stage_q <= err_stage_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // stage_en is decoded from state, so a reset drops it in the next cycle.
  assign bus.stage_en    = (state_q == S_ISSUE)
                           ? ({{(NUM_STAGES-1){1'b0}}, 1'b1} << cur_stage_q)
                           : '0;
  assign bus.pc          = pc_q;
  assign bus.cur_stage   = cur_stage_q;
  assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.retire      = retire_q;
  assign bus.instret     = instret_q;
  assign bus.timeout_err = (state_q == S_ERROR);
  assign bus.err_stage   = err_stage_q;

endmodule
